// File: rtl/nmk112_rom_arbiter_pkg.sv
// Shared types and constants for the NMK112 sample-ROM arbiter.
// The ROM address is a 6-bit bank followed by a 16-bit offset.
package nmk112_rom_arbiter_pkg;

  localparam int ROM_AW = 22;
  localparam int BANK_W = 6;
  localparam int OFS_W  = 16;

  localparam logic CH1 = 1'b0;
  localparam logic CH2 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CHK  = 2'd1,
    ST_ROM  = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  function automatic logic [ROM_AW-1:0] rom_addr(input logic [BANK_W-1:0] bank,
                                                 input logic [OFS_W-1:0]  ofs);
    return {bank, ofs};
  endfunction

endpackage

// File: rtl/nmk112_arb_chan.sv
// One OKI channel: strobe capture, latched ROM address, pending flag,
// one-entry last-byte cache and the registered ACK/D outputs.
module nmk112_arb_chan
  import nmk112_rom_arbiter_pkg::*;
#(
  parameter int CACHE_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stb_i,
  input  logic [17:0]       a_i,
  input  logic [BANK_W-1:0] bank_i,
  input  logic              done_i,
  input  logic              hit_load_i,
  input  logic              rom_load_i,
  input  logic [7:0]        rom_d_i,
  output logic              pending_o,
  output logic              hit_o,
  output logic [ROM_AW-1:0] addr_o,
  output logic              ack_o,
  output logic [7:0]        d_o
);

  logic              pending_q, pending_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [ROM_AW-1:0] tag_q, tag_d;
  logic              valid_q, valid_d;
  logic [7:0]        cdata_q, cdata_d;
  logic              ack_q, ack_d;
  logic [7:0]        dout_q, dout_d;
  logic              accept_s;
  logic [1:0]        a_unused_s;

  // A[17:16] lie outside the 16-bit bank window and never reach the ROM
  assign a_unused_s = a_i[17:16];
  assign accept_s   = stb_i && (!pending_q || done_i);

  // Next-state for request capture, cache fill and output registers
  always_comb begin
    pending_d = pending_q;
    addr_d    = addr_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    cdata_d   = cdata_q;
    ack_d     = 1'b0;
    dout_d    = dout_q;
    if (accept_s) begin
      pending_d = 1'b1;
      addr_d    = rom_addr(bank_i, a_i[15:0]);
    end else if (done_i) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (rom_load_i) begin
      dout_d  = rom_d_i;
      cdata_d = rom_d_i;
      tag_d   = addr_q;
      valid_d = 1'b1;
      ack_d   = 1'b1;
    end else if (hit_load_i) begin
      dout_d = cdata_q;
      ack_d  = 1'b1;
    end else begin
      ack_d = 1'b0;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      cdata_q   <= 8'h00;
      ack_q     <= 1'b0;
      dout_q    <= 8'h00;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      cdata_q   <= cdata_d;
      ack_q     <= ack_d;
      dout_q    <= dout_d;
    end
  end

  assign pending_o = pending_q;
  assign hit_o     = (CACHE_EN != 32'sd0) && valid_q && (tag_q == addr_q);
  assign addr_o    = addr_q;
  assign ack_o     = ack_q;
  assign d_o       = dout_q;

endmodule

// File: rtl/nmk112_rom_arbiter.sv
// Arbitrates the two OKI channels onto one variable-latency sample-ROM
// read port, round-robin on ties, with a per-channel last-byte cache.
module nmk112_rom_arbiter
  import nmk112_rom_arbiter_pkg::*;
#(
  parameter int CACHE_EN = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              OKI1_STB,
  input  logic [17:0]       OKI1_A,
  input  logic [BANK_W-1:0] OKI1_BANK,
  output logic              OKI1_ACK,
  output logic [7:0]        OKI1_D,
  input  logic              OKI2_STB,
  input  logic [17:0]       OKI2_A,
  input  logic [BANK_W-1:0] OKI2_BANK,
  output logic              OKI2_ACK,
  output logic [7:0]        OKI2_D,
  output logic              ROM_CS,
  output logic [ROM_AW-1:0] ROM_A,
  input  logic              ROM_OK,
  input  logic [7:0]        ROM_D
);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              rom_cs_q, rom_cs_d;
  logic [ROM_AW-1:0] rom_a_q, rom_a_d;

  logic [1:0]        pending_s, hit_s, done_s, hit_load_s, rom_load_s;
  logic [ROM_AW-1:0] addr1_s, addr2_s, gaddr_s;

  assign gaddr_s = (grant_q == CH2) ? addr2_s : addr1_s;

  nmk112_arb_chan #(.CACHE_EN(CACHE_EN)) u_chan1 (
    .clk(CLK), .rst_n(nRST), .stb_i(OKI1_STB), .a_i(OKI1_A), .bank_i(OKI1_BANK),
    .done_i(done_s[CH1]), .hit_load_i(hit_load_s[CH1]), .rom_load_i(rom_load_s[CH1]),
    .rom_d_i(ROM_D), .pending_o(pending_s[CH1]), .hit_o(hit_s[CH1]), .addr_o(addr1_s),
    .ack_o(OKI1_ACK), .d_o(OKI1_D)
  );

  nmk112_arb_chan #(.CACHE_EN(CACHE_EN)) u_chan2 (
    .clk(CLK), .rst_n(nRST), .stb_i(OKI2_STB), .a_i(OKI2_A), .bank_i(OKI2_BANK),
    .done_i(done_s[CH2]), .hit_load_i(hit_load_s[CH2]), .rom_load_i(rom_load_s[CH2]),
    .rom_d_i(ROM_D), .pending_o(pending_s[CH2]), .hit_o(hit_s[CH2]), .addr_o(addr2_s),
    .ack_o(OKI2_ACK), .d_o(OKI2_D)
  );

  // Arbiter next-state and per-channel load strobes
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    rom_cs_d   = rom_cs_q;
    rom_a_d    = rom_a_q;
    done_s     = 2'b00;
    hit_load_s = 2'b00;
    rom_load_s = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (pending_s[CH1] && pending_s[CH2]) begin
          grant_d = (last_q == CH1) ? CH2 : CH1;
          state_d = ST_CHK;
        end else if (pending_s[CH1]) begin
          grant_d = CH1;
          state_d = ST_CHK;
        end else if (pending_s[CH2]) begin
          grant_d = CH2;
          state_d = ST_CHK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (hit_s[grant_q]) begin
          hit_load_s[grant_q] = 1'b1;
          state_d             = ST_DONE;
        end else begin
          rom_a_d  = gaddr_s;
          rom_cs_d = 1'b1;
          state_d  = ST_ROM;
        end
      end
      ST_ROM: begin
        if (ROM_OK) begin
          rom_load_s[grant_q] = 1'b1;
          rom_cs_d            = 1'b0;
          state_d             = ST_DONE;
        end else begin
          state_d = ST_ROM;
        end
      end
      ST_DONE: begin
        done_s[grant_q] = 1'b1;
        last_d          = grant_q;
        state_d         = ST_IDLE;
      end
      default: begin
        rom_cs_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Arbiter registers; LAST resets to OKI2 so OKI1 wins the first tie
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      grant_q  <= CH1;
      last_q   <= CH2;
      rom_cs_q <= 1'b0;
      rom_a_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      rom_cs_q <= rom_cs_d;
      rom_a_q  <= rom_a_d;
    end
  end

  assign ROM_CS = rom_cs_q;
  assign ROM_A  = rom_a_q;

endmodule

// File: tb/tb_nmk112_rom_arbiter.sv
// Directed, table-driven bench for nmk112_rom_arbiter with a small
// ROM responder whose data is a fixed function of the address.
module tb_nmk112_rom_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        OKI1_STB = 1'b0, OKI2_STB = 1'b0;
  logic [17:0] OKI1_A = 18'h0, OKI2_A = 18'h0;
  logic [5:0]  OKI1_BANK = 6'h0, OKI2_BANK = 6'h0;
  logic        OKI1_ACK, OKI2_ACK;
  logic [7:0]  OKI1_D, OKI2_D;
  logic        ROM_CS;
  logic [21:0] ROM_A;
  logic        ROM_OK = 1'b1;
  logic [7:0]  ROM_D = 8'hEE;

  int checks = 0;
  int failures = 0;
  int rom_lat_v = 1;
  int cs_cnt = 0;

  typedef struct {
    logic        ch;
    logic [17:0] a;
    logic [5:0]  bank;
    int          lat;
    logic        hit;
    logic [21:0] rom_a;
    logic [7:0]  d;
    int          k;
  } txn_t;

  txn_t tbl [8];

  always #5 CLK = ~CLK;

  nmk112_rom_arbiter #(.CACHE_EN(1)) dut (
    .CLK(CLK), .nRST(nRST),
    .OKI1_STB(OKI1_STB), .OKI1_A(OKI1_A), .OKI1_BANK(OKI1_BANK), .OKI1_ACK(OKI1_ACK), .OKI1_D(OKI1_D),
    .OKI2_STB(OKI2_STB), .OKI2_A(OKI2_A), .OKI2_BANK(OKI2_BANK), .OKI2_ACK(OKI2_ACK), .OKI2_D(OKI2_D),
    .ROM_CS(ROM_CS), .ROM_A(ROM_A), .ROM_OK(ROM_OK), .ROM_D(ROM_D)
  );

  function automatic logic [7:0] rom_byte(input logic [21:0] a);
    return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
  endfunction

  // ROM model: answers in the rom_lat_v-th CS cycle; drives junk with OK=1 while idle
  always @(negedge CLK) begin
    if (ROM_CS) begin
      cs_cnt = cs_cnt + 1;
      if (cs_cnt == rom_lat_v) begin
        ROM_OK = 1'b1;
        ROM_D  = rom_byte(ROM_A);
      end else begin
        ROM_OK = 1'b0;
        ROM_D  = 8'hEE;
      end
    end else begin
      cs_cnt = 0;
      ROM_OK = 1'b1;
      ROM_D  = 8'hEE;
    end
  end

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=0x%0h expected=0x%0h", tag, what, act, exp);
    end
  endtask

  function automatic logic ack_of(input logic ch);
    return (ch == 1'b0) ? OKI1_ACK : OKI2_ACK;
  endfunction

  function automatic logic [7:0] d_of(input logic ch);
    return (ch == 1'b0) ? OKI1_D : OKI2_D;
  endfunction

  task automatic drive(input logic ch, input logic v, input logic [17:0] a, input logic [5:0] b);
    if (ch == 1'b0) begin
      OKI1_STB = v; OKI1_A = a; OKI1_BANK = b;
    end else begin
      OKI2_STB = v; OKI2_A = a; OKI2_BANK = b;
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    drive(1'b0, 1'b0, 18'h0, 6'h0);
    drive(1'b1, 1'b0, 18'h0, 6'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  // One request; address/bank are scrambled after the strobe to prove latching
  task automatic run_one(input txn_t t, input string tag);
    int k;
    bit got, saw_cs, unstable, other;
    logic [21:0] a_seen;
    logic [7:0] d_seen;
    rom_lat_v = t.lat;
    @(negedge CLK);
    drive(t.ch, 1'b1, t.a, t.bank);
    k = 0; got = 0; saw_cs = 0; unstable = 0; other = 0; a_seen = '0; d_seen = '0;
    while (!got && k < 40) begin
      @(negedge CLK);
      k++;
      if (k == 1) drive(t.ch, 1'b0, ~t.a, ~t.bank);
      if (ROM_CS) begin
        if (!saw_cs) a_seen = ROM_A;
        else if (ROM_A !== a_seen) unstable = 1;
        saw_cs = 1;
      end
      if (ack_of(!t.ch)) other = 1;
      if (ack_of(t.ch)) begin
        got = 1;
        d_seen = d_of(t.ch);
      end
    end
    chk(tag, "ack_cycle", got ? k : -1, t.k);
    chk(tag, "rom_cs_used", 32'(saw_cs), 32'(!t.hit));
    if (!t.hit) begin
      chk(tag, "rom_a", 32'(a_seen), 32'(t.rom_a));
      chk(tag, "rom_a_stable", 32'(unstable), 32'd0);
    end
    chk(tag, "d", 32'(d_seen), 32'(t.d));
    chk(tag, "other_ack", 32'(other), 32'd0);
    @(negedge CLK);
    chk(tag, "ack_pulse", 32'(ack_of(t.ch)), 32'd0);
    chk(tag, "d_hold", 32'(d_of(t.ch)), 32'(t.d));
  endtask

  task automatic run_pair(output int k1, output int k2);
    int k;
    @(negedge CLK);
    drive(1'b0, 1'b1, 18'h00010, 6'h01);
    drive(1'b1, 1'b1, 18'h00020, 6'h02);
    k = 0; k1 = -1; k2 = -1;
    while ((k1 < 0 || k2 < 0) && k < 60) begin
      @(negedge CLK);
      k++;
      if (k == 1) begin
        drive(1'b0, 1'b0, 18'h00010, 6'h01);
        drive(1'b1, 1'b0, 18'h00020, 6'h02);
      end
      if (OKI1_ACK && k1 < 0) k1 = k;
      if (OKI2_ACK && k2 < 0) k2 = k;
    end
  endtask

  initial begin
    int k, k1, k2, ka1, ka2, nack, bad;
    logic [21:0] a1, a2;
    logic [7:0] d1, d2;
    txn_t t;

    tbl[0] = '{1'b0, 18'h21234, 6'h05, 3, 1'b0, 22'h051234, 8'h23, 6};
    tbl[1] = '{1'b0, 18'h21234, 6'h05, 3, 1'b1, 22'h000000, 8'h23, 3};
    tbl[2] = '{1'b0, 18'h21234, 6'h06, 1, 1'b0, 22'h061234, 8'h20, 4};
    tbl[3] = '{1'b0, 18'h21234, 6'h05, 2, 1'b0, 22'h051234, 8'h23, 5};
    tbl[4] = '{1'b1, 18'h0FFFF, 6'h3F, 1, 1'b0, 22'h3FFFFF, 8'h3F, 4};
    tbl[5] = '{1'b1, 18'h0FFFF, 6'h3F, 1, 1'b1, 22'h000000, 8'h3F, 3};
    tbl[6] = '{1'b1, 18'h0A5C3, 6'h2A, 2, 1'b0, 22'h2AA5C3, 8'h4C, 5};
    tbl[7] = '{1'b0, 18'h11234, 6'h05, 1, 1'b1, 22'h000000, 8'h23, 3};

    // reset defaults with ROM_OK held high by the responder
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst", "rom_cs", 32'(ROM_CS), 32'd0);
    chk("rst", "rom_a", 32'(ROM_A), 32'd0);
    chk("rst", "ack1", 32'(OKI1_ACK), 32'd0);
    chk("rst", "ack2", 32'(OKI2_ACK), 32'd0);
    chk("rst", "d1", 32'(OKI1_D), 32'd0);
    chk("rst", "d2", 32'(OKI2_D), 32'd0);
    nRST = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge CLK);
      if (ROM_CS || OKI1_ACK || OKI2_ACK) bad++;
    end
    chk("rst", "quiet_after_release", bad, 0);

    for (int i = 0; i < 8; i++) run_one(tbl[i], $sformatf("vec%0d", i));

    // tie after reset: OKI1 first; after a lone OKI1 hit the next tie goes to OKI2
    do_reset();
    rom_lat_v = 1;
    run_pair(k1, k2);
    chk("tieA", "oki1_cycle", k1, 4);
    chk("tieA", "oki2_cycle", k2, 8);
    chk("tieA", "d1", 32'(OKI1_D), 32'h11);
    chk("tieA", "d2", 32'(OKI2_D), 32'h22);
    t = '{1'b0, 18'h00010, 6'h01, 1, 1'b1, 22'h0, 8'h11, 3};
    run_one(t, "lone1");
    run_pair(k1, k2);
    chk("tieB", "oki2_cycle", k2, 3);
    chk("tieB", "oki1_cycle", k1, 6);

    // back-to-back on OKI2; a strobe while pending is dropped
    rom_lat_v = 1;
    @(negedge CLK);
    drive(1'b1, 1'b1, 18'h0BEEF, 6'h11);
    k = 0; ka1 = -1; ka2 = -1; nack = 0; a1 = '0; a2 = '0; d1 = '0; d2 = '0;
    while (nack < 2 && k < 40) begin
      @(negedge CLK);
      k++;
      if (k == 1) drive(1'b1, 1'b1, 18'h0CAFE, 6'h12);
      if (k == 2) drive(1'b1, 1'b0, 18'h0CAFE, 6'h12);
      if (ka1 > 0 && k == ka1 + 1) drive(1'b1, 1'b0, 18'h00F00, 6'h13);
      if (ROM_CS) begin
        if (nack == 0) a1 = ROM_A;
        else a2 = ROM_A;
      end
      if (OKI2_ACK) begin
        nack++;
        if (nack == 1) begin
          ka1 = k; d1 = OKI2_D;
          drive(1'b1, 1'b1, 18'h00F00, 6'h13);
        end else begin
          ka2 = k; d2 = OKI2_D;
        end
      end
    end
    chk("b2b", "ack1_cycle", ka1, 4);
    chk("b2b", "rom_a1", 32'(a1), 32'h11BEEF);
    chk("b2b", "d1", 32'(d1), 32'h40);
    chk("b2b", "ack2_cycle", ka2, 8);
    chk("b2b", "rom_a2", 32'(a2), 32'h130F00);
    chk("b2b", "d2", 32'(d2), 32'h1C);
    bad = 0;
    repeat (8) begin
      @(negedge CLK);
      if (ROM_CS || OKI2_ACK || OKI1_ACK) bad++;
    end
    chk("b2b", "no_third_request", bad, 0);

    // reset while the ROM access is outstanding
    rom_lat_v = 20;
    @(negedge CLK);
    drive(1'b0, 1'b1, 18'h03333, 6'h09);
    k = 0;
    while (!ROM_CS && k < 20) begin
      @(negedge CLK);
      k++;
      if (k == 1) drive(1'b0, 1'b0, 18'h03333, 6'h09);
    end
    chk("midrst", "cs_seen", 32'(ROM_CS), 32'd1);
    @(negedge CLK);
    #1 nRST = 1'b0;
    #1;
    chk("midrst", "cs_async_drop", 32'(ROM_CS), 32'd0);
    bad = 0;
    repeat (3) begin
      @(negedge CLK);
      if (OKI1_ACK || OKI2_ACK) bad++;
    end
    nRST = 1'b1;
    rom_lat_v = 2;
    repeat (6) begin
      @(negedge CLK);
      if (OKI1_ACK || OKI2_ACK || ROM_CS) bad++;
    end
    chk("midrst", "no_ack_no_rom", bad, 0);
    t = '{1'b0, 18'h03333, 6'h09, 2, 1'b0, 22'h093333, 8'h09, 5};
    run_one(t, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nmk112_rom_arbiter.md
Name: nmk112_rom_arbiter

Overview:
- Sits directly downstream of NMK_112. Combines each OKI's sample address with its NMK_112 bank output into a 22-bit sample-ROM address.
- Arbitrates the two OKI channels onto one shared, variable-latency sample-ROM read port and returns the fetched byte to the requesting channel.
- Holds a one-entry last-byte cache per channel, so repeated reads of the same address (OKI nibble re-fetches) do not reach the ROM.

Parameters:
ROM_AW, 22, ROM address width; fixed as 6 bank bits plus 16 offset bits.
CACHE_EN, 1, 1 enables the per-channel last-byte cache; 0 sends every request to the ROM.

Ports:
CLK  in  1  system clock
nRST  in  1  asynchronous active-low reset
OKI1_STB  in  1  one-cycle read strobe from OKI1
OKI1_A  in  18  OKI1 sample address
OKI1_BANK  in  6  bank for OKI1 from NMK_112
OKI1_ACK  out  1  one-cycle pulse: OKI1_D valid
OKI1_D  out  8  byte returned to OKI1
OKI2_STB, OKI2_A, OKI2_BANK, OKI2_ACK, OKI2_D  as OKI1, for OKI2
ROM_CS  out  1  ROM read request, held until ROM_OK
ROM_A  out  22  ROM byte address
ROM_OK  in  1  ROM data valid; only meaningful while ROM_CS=1
ROM_D  in  8  ROM data

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous, active-low.
- Reset values: ROM_CS=0; ROM_A=0; both ACK=0; both D=0x00. Pending flags, cache-valid flags and the state machine are cleared. Round-robin pointer LAST=2, so OKI1 wins the first tie.
- Address formation: full address = {BANK, A[15:0]}. It is latched per channel on the STB cycle. BANK or A changes after the strobe do not affect that request.
- Request capture: STB=1 sets the channel's pending flag on the next edge.
  - STB while the channel is already pending or in service is ignored; the latched address is kept.
  - STB in the same cycle as that channel's ACK is accepted as a new request.
- States: IDLE, CHK, ROM, DONE.
  - IDLE: if any channel is pending, grant it. If both are pending, grant the channel other than LAST. Latch grant, go to CHK.
  - CHK: if CACHE_EN, the cache entry is valid and the tag equals the latched address, load D from cache and go to DONE. Otherwise register ROM_A, set ROM_CS=1, go to ROM.
  - ROM: hold ROM_CS and ROM_A stable. When ROM_OK=1: capture ROM_D into the channel's D and cache data, write the tag, set cache valid, drop ROM_CS, go to DONE.
  - DONE: pulse the granted ACK for one cycle, clear pending, set LAST=grant, go to IDLE.
- Latency: STB at cycle T. Pending visible at T+1 (IDLE). CHK at T+2.
  - Cache hit: ACK at T+3.
  - Miss: ROM_CS is high from T+3. If ROM_OK arrives at cycle R, ACK is at R+1.
  - The minimum miss is ACK at T+4 (ROM_OK in the first CS cycle).
- Data hold: D holds its value between ACKs; it changes only in the cycle ACK is asserted.
- ROM_OK while ROM_CS=0 is ignored.
- Only one ROM access is outstanding at a time. No timeout: ROM_OK never arriving stalls both channels.
- Reset mid-access: ROM_CS drops asynchronously; any in-flight request is lost with no ACK.
- A bank change by the CPU through NMK_112 does not invalidate the cache. Tags include the bank bits, so a new bank misses naturally.

Decomposition:
- Shared package: state enum (IDLE/CHK/ROM/DONE), ROM_AW, channel index constants CH1/CH2.
- One natural sub-module, nmk112_arb_chan, instanced twice. It holds one channel's strobe capture, latched address, pending flag, cache (tag/valid/data) and D/ACK output registers.
- The top level holds the arbiter FSM and the round-robin pointer.

Test Plan:
- Reset defaults: hold nRST low, drive ROM_OK=1 -> ROM_CS=0, ROM_A=0, both ACK=0, D=0x00; release reset -> no ROM activity.
- Single miss: OKI1_STB, A=0x2_1234, BANK=0x05, ROM returns 0xA7 after 3 CS cycles -> ROM_A=0x051234 held stable, OKI1_ACK one cycle after ROM_OK, OKI1_D=0xA7.
- Cache hit: repeat the same OKI1 request -> no ROM_CS, OKI1_ACK at T+3, D=0xA7. Change BANK to 0x06 -> miss, ROM_A=0x061234.
- Tie: both STB in the same cycle after reset -> OKI1 served first, then OKI2. Second simultaneous pair -> OKI2 served first.
- Back-to-back: OKI2_STB in the same cycle as OKI2_ACK -> accepted, second ACK follows. STB while pending -> ignored, ROM_A from the first address.
- Reset mid-access: assert nRST while ROM_CS=1 -> ROM_CS drops immediately, no ACK. After release, a new request completes normally.
